// File: rtl/fp_mult_seq.sv
// Sequential binary32 multiplier: one shared 24x12 mantissa multiplier used over two cycles.
// Truncates the product and flushes denormals to zero; a result is produced 3 edges after accept.
module fp_mult_seq (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        in_ready,
  output logic [31:0] q,
  output logic        q_valid
);

  typedef enum logic [1:0] {IDLE, LO, HI, NORM} state_t;

  state_t      state;
  logic        sign_p0;
  logic [7:0]  ea_p0;
  logic [7:0]  eb_p0;
  logic [23:0] ma_p0;
  logic [23:0] mb_p0;
  logic        nan_p0;
  logic        inf_p0;
  logic        zero_p0;
  logic [35:0] p_lo_p1;
  logic [47:0] acc_p2;

  logic [11:0]        mb_half;
  logic [35:0]        prod;
  logic signed [9:0]  e_sum;

  assign in_ready = (state == IDLE);

  // Low half of mb in LO, high half in HI, through the one multiplier.
  assign mb_half = (state == HI) ? mb_p0[23:12] : mb_p0[11:0];
  assign prod    = {12'd0, ma_p0} * {24'd0, mb_half};
  assign e_sum   = $signed({2'b00, ea_p0}) + $signed({2'b00, eb_p0}) - 10'sd127;

  function automatic logic [31:0] pack_result(
    input logic              s,
    input logic signed [9:0] e,
    input logic [47:0]       acc,
    input logic              nan,
    input logic              inf,
    input logic              zero
  );
    logic signed [9:0] e_n;
    logic [22:0]       frac;
    if (acc[47]) begin
      e_n  = e + 10'sd1;
      frac = acc[46:24];
    end else begin
      e_n  = e;
      frac = acc[45:23];
    end
    if (nan)                    pack_result = 32'h7FC0_0000;
    else if (inf)               pack_result = {s, 8'hFF, 23'h0};
    else if (zero)              pack_result = {s, 31'h0};
    else if (e_n >= 10'sd255)   pack_result = {s, 8'hFF, 23'h0};
    else if (e_n <= 10'sd0)     pack_result = {s, 31'h0};
    else                        pack_result = {s, e_n[7:0], frac};
  endfunction

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      sign_p0 <= 1'b0;
      ea_p0   <= 8'd0;
      eb_p0   <= 8'd0;
      ma_p0   <= 24'd0;
      mb_p0   <= 24'd0;
      nan_p0  <= 1'b0;
      inf_p0  <= 1'b0;
      zero_p0 <= 1'b0;
      p_lo_p1 <= 36'd0;
      acc_p2  <= 48'd0;
      q       <= 32'd0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      case (state)
        // Accept: capture operands and classify specials.
        IDLE: begin
          if (start) begin
            sign_p0 <= a[31] ^ b[31];
            ea_p0   <= a[30:23];
            eb_p0   <= b[30:23];
            ma_p0   <= {1'b1, a[22:0]};
            mb_p0   <= {1'b1, b[22:0]};
            nan_p0  <= (a[30:23] == 8'hFF && b[30:23] == 8'h00) ||
                       (b[30:23] == 8'hFF && a[30:23] == 8'h00);
            inf_p0  <= (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
            zero_p0 <= (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
            state   <= LO;
          end
        end
        // Partial product of the low 12 bits of mb.
        LO: begin
          p_lo_p1 <= prod;
          state   <= HI;
        end
        // Accumulate the high partial product shifted into place.
        HI: begin
          acc_p2 <= {12'd0, p_lo_p1} + {prod, 12'd0};
          state  <= NORM;
        end
        // Normalise, apply specials, publish.
        NORM: begin
          q       <= pack_result(sign_p0, e_sum, acc_p2, nan_p0, inf_p0, zero_p0);
          q_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq: directed vectors with literal expectations plus a per-cycle
// comparison against a full-product reference model.
module tb_fp_mult_seq;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_ready;
  logic [31:0] q;
  logic        q_valid;

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

  fp_mult_seq dut (
    .clk      (clk),
    .arst     (arst),
    .start    (start),
    .a        (a),
    .b        (b),
    .in_ready (in_ready),
    .q        (q),
    .q_valid  (q_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: full 48-bit product, truncation, flush-to-zero.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          ex, ey, e;
    longint      p;
    logic [22:0] f;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0)) return 32'h7FC0_0000;
    if (ex == 255 || ey == 255) return {s, 8'hFF, 23'h0};
    if (ex == 0 || ey == 0) return {s, 31'h0};
    p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
    e = ex + ey - 127;
    if (p >= (longint'(1) << 47)) begin
      e = e + 1;
      f = 23'(p >>> 24);
    end else begin
      f = 23'(p >>> 23);
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), f};
  endfunction

  // Cycle model: busy count since accept, expected output registers.
  int          m_cnt;
  logic [31:0] m_a, m_b, m_q;
  logic        m_qv;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_cnt <= 0;
      m_q   <= 32'd0;
      m_qv  <= 1'b0;
    end else begin
      m_qv <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_a   <= a;
          m_b   <= b;
          m_cnt <= 1;
        end
      end else if (m_cnt == 3) begin
        m_q   <= ref_mul(m_a, m_b);
        m_qv  <= 1'b1;
        m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_in_ready", {31'd0, in_ready}, {31'd0, m_cnt == 0});
      chk("mon_q_valid", {31'd0, q_valid}, {31'd0, m_qv});
      chk("mon_q", q, m_q);
    end
  end

  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: in_ready never rose", nm);
      start = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    chk({nm, "_busy0"}, {31'd0, in_ready}, 32'd0);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      chk({nm, "_busy"}, {31'd0, in_ready}, 32'd0);
      chk({nm, "_early_qv"}, {31'd0, q_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk({nm, "_qv"}, {31'd0, q_valid}, 32'd1);
    chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_q"}, q, exp);
  endtask

  initial begin
    int pulses;
    arst  = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;

    // Pin the reference model with hand-computed values.
    chk("ref_1p5x2", ref_mul(32'h3FC00000, 32'h40000000), 32'h40400000);
    chk("ref_1p5x1p5", ref_mul(32'h3FC00000, 32'h3FC00000), 32'h40100000);
    chk("ref_ovf", ref_mul(32'h7F000000, 32'h7F000000), 32'h7F800000);
    chk("ref_nan", ref_mul(32'h00000000, 32'h7F800000), 32'h7FC00000);

    #12;
    chk("rst_q", q, 32'd0);
    chk("rst_qv", {31'd0, q_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #2;
    arst   = 1'b0;
    mon_on = 1'b1;

    do_op(32'h3FC00000, 32'h40000000, 32'h40400000, "mul_1p5x2");
    do_op(32'hC0400000, 32'h3F000000, 32'hBFC00000, "mul_m3xhalf");
    do_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, "mul_norm47");
    do_op(32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
    do_op(32'h00800000, 32'h00800000, 32'h00000000, "underflow");
    do_op(32'h00000001, 32'h3F800000, 32'h00000000, "denormal");
    do_op(32'h00000000, 32'h7F800000, 32'h7FC00000, "zero_x_inf");
    do_op(32'hFF800000, 32'h40000000, 32'hFF800000, "ninf_x2");

    // start held high with fresh operands every cycle.
    @(negedge clk);
    start  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      if (q_valid) pulses++;
    end
    start = 1'b0;
    chk("stream_pulses", pulses, 32'd12);

    do_op(32'h40400000, 32'h40400000, 32'h41100000, "mul_3x3");

    // Abort during HI.
    @(negedge clk);
    start = 1'b1;
    a = 32'h3FC00000;
    b = 32'h40000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    chk("abort_q", q, 32'd0);
    chk("abort_qv", {31'd0, q_valid}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #2;
    arst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (q_valid) pulses++;
    end
    chk("abort_no_qv", pulses, 32'd0);

    do_op(32'h3FC00000, 32'h40000000, 32'h40400000, "post_abort");

    repeat (2) @(negedge clk);
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
